instr_frontend: RTL
===================

# instr_frontend

Instruction front end feeding the CPU's `control_logic`: consumes the 32-bit control word that `control_logic` emits and drives back its `opcode`, `flags`, `step_resetn` and `step_extn` inputs. Latches opcodes from the data bus, arms the extended-opcode path after an XPREFIX step, registers ALU flags, and sequences reset, halt and resume. Sits between the data bus / ALU and `control_logic`, closing the microcode loop.

## Interface
Parameters:
- `XPREFIX`, 8'hEE: opcode byte marking an extended instruction.

Ports:
- `clk`  in  1: system clock; all state updates on its rising edge.
- `rstn`  in  1: reset, asynchronous and active-low.
- `control_word`  in  32: current microcode word from `control_logic`.
- `bus_in`  in  8: data bus value.
- `alu_flags`  in  4: live ALU flags, in `control_logic` flag order.
- `resume`  in  1: single-cycle pulse that leaves HALT.
- `opcode`  out  8: registered opcode to `control_logic`.
- `flags`  out  4: registered flags to `control_logic`.
- `step_resetn`  out  1: active-low step-counter reset to `control_logic`.
- `step_extn`  out  1: active-low extended-page select to `control_logic`.
- `halted`  out  1: high while in HALT, used by the clock module.

## Operation
Control-word fields, decoded here:
- `CW_STEP_RST_N` = bit 24, active-low.
- `CW_STEP_EXT_N` = bit 25, active-low.
- `CW_IR_LOAD` = bit 27, active-high.
- `CW_FLAGS_LOAD` = bit 28, active-high.
- `CW_HALT` = bit 29, active-high.

Register behaviour:
- Opcode register loads `bus_in` on any edge with `CW_IR_LOAD`=1 and state RUN. A loaded value of `XPREFIX` is stored as-is.
- Flags register loads `alu_flags` on any edge with `CW_FLAGS_LOAD`=1 and state RUN.
- `ext_armed` sets on an edge with `CW_STEP_EXT_N`=0 in RUN. It clears on the next edge with `CW_IR_LOAD`=1. If both conditions occur on the same edge, set wins.

Output decode:
- `step_extn` = ~`ext_armed`.
- `step_resetn` = 0 in INIT and HALT, 1 in RUN.
- `halted` = 1 only in HALT.

State machine:
- INIT is entered on reset and lasts exactly one cycle, then goes to RUN.
- RUN goes to HALT on an edge with `CW_HALT`=1. `resume` is ignored in RUN.
- HALT goes to INIT on an edge with `resume`=1, so fetch restarts with the step counter cleared. `control_word` is ignored in HALT.
- The opcode, flags and `ext_armed` registers hold through HALT and INIT.

Reset values, including reset asserted mid-operation:
- state = INIT.
- `opcode` = 8'h00, `flags` = 4'h0.
- `ext_armed` = 0, so `step_extn` = 1.
- `step_resetn` = 0, `halted` = 0.

`control_word` bits not listed above are ignored.

## Timing
- Every registered output changes only on the rising edge of `clk`, except on asynchronous reset assertion.
- `opcode` and `flags` are valid one edge after the load-qualifying control word. `control_logic` therefore sees the new opcode in the following step.
- `step_extn` goes low the cycle after the XPREFIX step. It stays low up to and including the cycle whose edge loads the extended opcode, and returns to 1 the cycle after that edge.
- After reset release, `step_resetn` is 0 for exactly one clock, then 1.
- From the `CW_HALT` edge to the first RUN cycle after `resume` takes 2 edges: HALT→INIT, then INIT→RUN.
- There is no combinational path from `bus_in` or `alu_flags` to any output.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the `CW_*` bit-index localparams;
  - the state enum `{INIT, RUN, HALT}`;
  - `XPREFIX_OP` = 8'hEE.
- `control_logic` imports the same package, so the field map has one source of truth.
- One sub-module, `ext_prefix_latch`, holds `ext_armed` with its set/clear priority. The remaining logic is flat.

## Test plan
- **Reset:** assert `rstn`=0 mid-run with `opcode`=8'h17 → outputs go immediately to opcode 00, flags 0, `step_resetn` 0, `step_extn` 1, `halted` 0. Release → `step_resetn` is 0 for one cycle, then 1.
- **Fetch:** in RUN, `control_word` with `CW_IR_LOAD`, `bus_in`=8'h01 → `opcode`=8'h01 after one edge. A later edge with `CW_IR_LOAD`=0 and `bus_in`=8'hFF leaves `opcode` at 01.
- **Flags:** `alu_flags`=4'h4 with `CW_FLAGS_LOAD` → `flags`=4'h4 next edge. Change `alu_flags` without the load → `flags` stays 4'h4.
- **Extended prefix:**
  - Load 8'hEE, then an edge with `CW_STEP_EXT_N`=0 → `step_extn`=0.
  - Hold for 2 further non-load cycles → `step_extn` stays 0.
  - Load 8'h0D → `opcode`=8'h0D and `step_extn`=1 after that edge.
  - Same edge carrying both `CW_STEP_EXT_N`=0 and `CW_IR_LOAD` → `step_extn` stays 0.
- **Halt/resume:**
  - `CW_HALT` edge → `halted`=1 and `step_resetn`=0. Further `CW_IR_LOAD` words leave `opcode` unchanged.
  - `resume` pulse → one INIT cycle (`halted`=0, `step_resetn`=0), then RUN.
- **Ignored resume:** `resume` pulse while in RUN → no state change, `step_resetn` stays 1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-word field map, sequencer states and opcode constants.
// control_logic imports this same package so the field map lives in one place.
package cpu_ctrl_pkg;

    // Control-word bit positions
    localparam int unsigned CW_STEP_RST_N = 24;  // active-low
    localparam int unsigned CW_STEP_EXT_N = 25;  // active-low
    localparam int unsigned CW_IR_LOAD    = 27;  // active-high
    localparam int unsigned CW_FLAGS_LOAD = 28;  // active-high
    localparam int unsigned CW_HALT       = 29;  // active-high

    // Opcode byte that marks an extended instruction
    localparam logic [7:0] XPREFIX_OP = 8'hEE;

    // Front-end sequencer states
    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/instr_frontend_if.sv
// Signal bundle between the data bus / ALU / control_logic side and the
// instruction front end.
interface instr_frontend_if;

    logic [31:0] control_word;
    logic [7:0]  bus_in;
    logic [3:0]  alu_flags;
    logic        resume;
    logic [7:0]  opcode;
    logic [3:0]  flags;
    logic        step_resetn;
    logic        step_extn;
    logic        halted;

    // Driven by control_logic, the data bus and the ALU
    modport master (
        output control_word,
        output bus_in,
        output alu_flags,
        output resume,
        input  opcode,
        input  flags,
        input  step_resetn,
        input  step_extn,
        input  halted
    );

    // The front end itself
    modport slave (
        input  control_word,
        input  bus_in,
        input  alu_flags,
        input  resume,
        output opcode,
        output flags,
        output step_resetn,
        output step_extn,
        output halted
    );

endinterface

// File: rtl/instr_frontend_ext_prefix_latch.sv
// Holds the "extended opcode armed" bit. Armed by an XPREFIX step, disarmed
// by the next opcode load; when both happen on one edge, arming wins so a
// prefix step that also loads still selects the extended page.
module ext_prefix_latch (
    input  logic clk,
    input  logic rstn,
    input  logic set,
    input  logic clr,
    output logic armed
);

    logic armed_r;

    // Armed flag with set-over-clear priority
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            armed_r <= 1'b0;
        end else if (set) begin
            armed_r <= 1'b1;
        end else if (clr) begin
            armed_r <= 1'b0;
        end else begin
            armed_r <= armed_r;
        end
    end

    assign armed = armed_r;

endmodule

// File: rtl/instr_frontend.sv
// Instruction front end: latches opcodes and ALU flags for control_logic,
// tracks the extended-opcode prefix and sequences INIT / RUN / HALT.
// All outputs come straight from flops; bus_in and alu_flags only reach
// outputs through registers.
module instr_frontend
    import cpu_ctrl_pkg::*;
#(
    parameter logic [7:0] XPREFIX = XPREFIX_OP
) (
    input  logic            clk,
    input  logic            rstn,
    instr_frontend_if.slave fe
);

    state_t     state_r;
    logic       step_resetn_r;
    logic       halted_r;
    logic [7:0] opcode_r;
    logic [3:0] flags_r;
    logic       run_s;
    logic       ir_load_s;
    logic       flags_load_s;
    logic       ext_set_s;
    logic       ext_clr_s;
    logic       ext_armed_s;

    // Control-word fields only act while running; HALT and INIT ignore them
    always_comb begin
        run_s        = (state_r == RUN);
        ir_load_s    = run_s && fe.control_word[CW_IR_LOAD];
        flags_load_s = run_s && fe.control_word[CW_FLAGS_LOAD];
        ext_set_s    = run_s && !fe.control_word[CW_STEP_EXT_N];
        ext_clr_s    = ir_load_s;
    end

    // Sequencer with registered step-counter reset and halt indication
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= INIT;
            step_resetn_r <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    state_r       <= RUN;
                    step_resetn_r <= 1'b1;
                    halted_r      <= 1'b0;
                end
                RUN: begin
                    if (fe.control_word[CW_HALT]) begin
                        state_r       <= HALT;
                        step_resetn_r <= 1'b0;
                        halted_r      <= 1'b1;
                    end else begin
                        state_r       <= RUN;
                        step_resetn_r <= 1'b1;
                        halted_r      <= 1'b0;
                    end
                end
                HALT: begin
                    if (fe.resume) begin
                        // Restart fetch through INIT so the step counter is cleared
                        state_r       <= INIT;
                        step_resetn_r <= 1'b0;
                        halted_r      <= 1'b0;
                    end else begin
                        state_r       <= HALT;
                        step_resetn_r <= 1'b0;
                        halted_r      <= 1'b1;
                    end
                end
                default: begin
                    state_r       <= INIT;
                    step_resetn_r <= 1'b0;
                    halted_r      <= 1'b0;
                end
            endcase
        end
    end

    // Opcode register; an XPREFIX byte is stored unchanged like any other
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            opcode_r <= 8'h00;
        end else if (ir_load_s) begin
            opcode_r <= fe.bus_in;
        end else begin
            opcode_r <= opcode_r;
        end
    end

    // Flags register, loaded from the live ALU flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flags_r <= 4'h0;
        end else if (flags_load_s) begin
            flags_r <= fe.alu_flags;
        end else begin
            flags_r <= flags_r;
        end
    end

    ext_prefix_latch u_ext_prefix_latch (
        .clk   (clk),
        .rstn  (rstn),
        .set   (ext_set_s),
        .clr   (ext_clr_s),
        .armed (ext_armed_s)
    );

    assign fe.opcode      = opcode_r;
    assign fe.flags       = flags_r;
    assign fe.step_resetn = step_resetn_r;
    assign fe.step_extn   = ~ext_armed_s;
    assign fe.halted      = halted_r;

endmodule
